// File: rtl/apb_bus_arbiter.sv
// APB slave-bus arbiter: grants one master per complete SETUP/ACCESS transfer,
// fixed-priority or round-robin. Define APB_BUS_ARBITER_TIMEOUT_EN to build the transfer watchdog.
module apb_bus_arbiter #(
    parameter int NO_OF_MASTERS    = 4,
    parameter int MASTER_ID_WIDTH  = 2,
    parameter int ARBITRATION_TYPE = 0,
    parameter int TIMEOUT_CYCLES   = 16
) (
    input  logic                       I_PCLK,
    input  logic                       I_PRESET,
    input  logic [NO_OF_MASTERS-1:0]   I_REQ,
    input  logic [NO_OF_MASTERS-1:0]   I_PENABLE,
    input  logic                       I_PREADY,
    output logic [NO_OF_MASTERS-1:0]   O_GNT,
    output logic [MASTER_ID_WIDTH-1:0] O_GNT_ID,
    output logic                       O_GNT_VALID,
    output logic                       O_XFER_DONE,
    output logic                       O_TIMEOUT
);

    if (NO_OF_MASTERS < 1 || MASTER_ID_WIDTH < 1 || NO_OF_MASTERS > (1 << MASTER_ID_WIDTH) ||
        TIMEOUT_CYCLES < 2) begin : g_bad_cfg
        $error("apb_bus_arbiter: illegal parameter combination");
    end

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_e;

    localparam logic [MASTER_ID_WIDTH-1:0] LAST_ID = MASTER_ID_WIDTH'(NO_OF_MASTERS - 1);

    state_e                     state_q, state_d;
    logic [NO_OF_MASTERS-1:0]   gnt_q, gnt_d;
    logic [MASTER_ID_WIDTH-1:0] gnt_id_q, gnt_id_d;
    logic [MASTER_ID_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
    logic                       gnt_valid_q, gnt_valid_d;
    logic                       xfer_done_q, xfer_done_d;
    logic                       timeout_q, timeout_d;

    logic [NO_OF_MASTERS-1:0]   req_hi, cand, win_oh;
    logic [MASTER_ID_WIDTH-1:0] win_id;
    logic                       win_any;
    logic                       owner_req, owner_pen, expire;

    // Round-robin: prefer requesters at or above the pointer, else wrap to the lowest.
    always_comb begin
        for (int i = 0; i < NO_OF_MASTERS; i++) begin
            req_hi[i] = I_REQ[i] && (i >= int'(rr_ptr_q));
        end
        cand    = (ARBITRATION_TYPE == 1 && (|req_hi)) ? req_hi : I_REQ;
        win_oh  = '0;
        win_id  = '0;
        win_any = 1'b0;
        for (int i = 0; i < NO_OF_MASTERS; i++) begin
            if (cand[i] && !win_any) begin
                win_any   = 1'b1;
                win_oh[i] = 1'b1;
                win_id    = MASTER_ID_WIDTH'(i);
            end
        end
    end

    // The one-hot grant doubles as the owner select for its request/enable lines.
    assign owner_req = |(I_REQ & gnt_q);
    assign owner_pen = |(I_PENABLE & gnt_q);

`ifdef APB_BUS_ARBITER_TIMEOUT_EN
    localparam int             CNT_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] wd_cnt_q, wd_cnt_d;

    // Held at zero while idle so every grant starts a fresh count.
    always_comb begin
        wd_cnt_d = '0;
        if (state_q != IDLE) begin
            wd_cnt_d = wd_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge I_PCLK) begin
        if (I_PRESET) begin
            wd_cnt_q <= '0;
        end else begin
            wd_cnt_q <= wd_cnt_d;
        end
    end

    assign expire = (state_q != IDLE) && (wd_cnt_q == CNT_LAST);
`else
    assign expire = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        gnt_id_d    = gnt_id_q;
        gnt_valid_d = gnt_valid_q;
        rr_ptr_d    = rr_ptr_q;
        xfer_done_d = 1'b0;
        timeout_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (win_any) begin
                    state_d     = SETUP;
                    gnt_d       = win_oh;
                    gnt_id_d    = win_id;
                    gnt_valid_d = 1'b1;
                    if (ARBITRATION_TYPE == 1) begin
                        rr_ptr_d = (win_id == LAST_ID) ? '0 : win_id + MASTER_ID_WIDTH'(1);
                    end
                end
            end
            SETUP: begin
                if (expire) begin
                    state_d   = IDLE;
                    timeout_d = 1'b1;
                end else if (owner_pen) begin
                    state_d = ACCESS;
                end else if (!owner_req) begin
                    state_d = IDLE;
                end
            end
            ACCESS: begin
                if (I_PREADY) begin
                    state_d     = IDLE;
                    xfer_done_d = 1'b1;
                end else if (expire) begin
                    state_d   = IDLE;
                    timeout_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (state_q != IDLE && state_d == IDLE) begin
            gnt_d       = '0;
            gnt_id_d    = '0;
            gnt_valid_d = 1'b0;
        end
    end

    always_ff @(posedge I_PCLK) begin
        if (I_PRESET) begin
            state_q     <= IDLE;
            gnt_q       <= '0;
            gnt_id_q    <= '0;
            gnt_valid_q <= 1'b0;
            rr_ptr_q    <= '0;
            xfer_done_q <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            gnt_id_q    <= gnt_id_d;
            gnt_valid_q <= gnt_valid_d;
            rr_ptr_q    <= rr_ptr_d;
            xfer_done_q <= xfer_done_d;
            timeout_q   <= timeout_d;
        end
    end

    assign O_GNT       = gnt_q;
    assign O_GNT_ID    = gnt_id_q;
    assign O_GNT_VALID = gnt_valid_q;
    assign O_XFER_DONE = xfer_done_q;
    assign O_TIMEOUT   = timeout_q;

endmodule

// File: tb/tb_apb_bus_arbiter.sv
// Directed bench for apb_bus_arbiter: fixed-priority instance (a) and round-robin instance (b).
// Watchdog expectations follow APB_BUS_ARBITER_TIMEOUT_EN.
module tb_apb_bus_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req_a, pen_a, req_b, pen_b;
    logic       rdy_a, rdy_b;
    logic [3:0] gnt_a, gnt_b;
    logic [1:0] id_a, id_b;
    logic       vld_a, vld_b, done_a, done_b, to_a, to_b;

    int vectors    = 0;
    int miscompares = 0;

`ifdef APB_BUS_ARBITER_TIMEOUT_EN
    localparam int STALL_HOLD = 15;
`else
    localparam int STALL_HOLD = 100;
`endif

    always #5 clk = ~clk;

    apb_bus_arbiter #(.NO_OF_MASTERS(4), .MASTER_ID_WIDTH(2), .ARBITRATION_TYPE(0),
                      .TIMEOUT_CYCLES(16)) u_a (
        .I_PCLK(clk), .I_PRESET(rst), .I_REQ(req_a), .I_PENABLE(pen_a), .I_PREADY(rdy_a),
        .O_GNT(gnt_a), .O_GNT_ID(id_a), .O_GNT_VALID(vld_a), .O_XFER_DONE(done_a),
        .O_TIMEOUT(to_a));

    apb_bus_arbiter #(.NO_OF_MASTERS(4), .MASTER_ID_WIDTH(2), .ARBITRATION_TYPE(1),
                      .TIMEOUT_CYCLES(16)) u_b (
        .I_PCLK(clk), .I_PRESET(rst), .I_REQ(req_b), .I_PENABLE(pen_b), .I_PREADY(rdy_b),
        .O_GNT(gnt_b), .O_GNT_ID(id_b), .O_GNT_VALID(vld_b), .O_XFER_DONE(done_b),
        .O_TIMEOUT(to_b));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_a(input string tag, input logic [3:0] g, input logic [1:0] id,
                            input logic d, input logic t);
        chk({tag, ".gnt"},  {28'd0, gnt_a}, {28'd0, g});
        chk({tag, ".id"},   {30'd0, id_a},  {30'd0, id});
        chk({tag, ".vld"},  {31'd0, vld_a}, {31'd0, (g != 4'd0)});
        chk({tag, ".done"}, {31'd0, done_a}, {31'd0, d});
        chk({tag, ".to"},   {31'd0, to_a},  {31'd0, t});
    endtask

    task automatic expect_b(input string tag, input logic [3:0] g, input logic [1:0] id,
                            input logic d, input logic t);
        chk({tag, ".gnt"},  {28'd0, gnt_b}, {28'd0, g});
        chk({tag, ".id"},   {30'd0, id_b},  {30'd0, id});
        chk({tag, ".vld"},  {31'd0, vld_b}, {31'd0, (g != 4'd0)});
        chk({tag, ".done"}, {31'd0, done_b}, {31'd0, d});
        chk({tag, ".to"},   {31'd0, to_b},  {31'd0, t});
    endtask

    initial begin
        logic [3:0] exp_oh;
        rst = 1'b1;
        req_a = '0; pen_a = '0; rdy_a = 1'b0;
        req_b = '0; pen_b = '0; rdy_b = 1'b0;
        tick(); tick();
        expect_a("rst_a", 4'b0000, 2'd0, 1'b0, 1'b0);
        expect_b("rst_b", 4'b0000, 2'd0, 1'b0, 1'b0);
        rst = 1'b0;

        // Fixed priority: lowest requester wins, two wait states, one dead cycle
        req_a = 4'b1010;
        tick(); expect_a("fp_grant",  4'b0010, 2'd1, 1'b0, 1'b0);
        tick(); expect_a("fp_setup",  4'b0010, 2'd1, 1'b0, 1'b0);
        pen_a = 4'b0010;
        tick(); expect_a("fp_access", 4'b0010, 2'd1, 1'b0, 1'b0);
        tick(); expect_a("fp_wait1",  4'b0010, 2'd1, 1'b0, 1'b0);
        tick(); expect_a("fp_wait2",  4'b0010, 2'd1, 1'b0, 1'b0);
        rdy_a = 1'b1;
        tick(); expect_a("fp_done",   4'b0000, 2'd0, 1'b1, 1'b0);
        pen_a = '0; rdy_a = 1'b0;
        tick(); expect_a("fp_regrant", 4'b0010, 2'd1, 1'b0, 1'b0);
        req_a = 4'b0000;
        tick(); expect_a("fp_withdraw", 4'b0000, 2'd0, 1'b0, 1'b0);
        req_a = 4'b1100;
        tick(); expect_a("fp_grant2", 4'b0100, 2'd2, 1'b0, 1'b0);
        req_a = 4'b1000;
        tick(); expect_a("fp_withdraw2", 4'b0000, 2'd0, 1'b0, 1'b0);
        tick(); expect_a("fp_grant3", 4'b1000, 2'd3, 1'b0, 1'b0);
        req_a = 4'b0000; pen_a = 4'b1000;
        tick(); expect_a("fp_pen_beats_wd", 4'b1000, 2'd3, 1'b0, 1'b0);
        rdy_a = 1'b1;
        tick(); expect_a("fp_done3", 4'b0000, 2'd0, 1'b1, 1'b0);
        pen_a = 4'b1111; rdy_a = 1'b1;
        tick(); expect_a("fp_idle_ignore", 4'b0000, 2'd0, 1'b0, 1'b0);
        pen_a = '0; rdy_a = 1'b0;

        // Stalled slave: watchdog behaviour depends on the build
        req_a = 4'b0001;
        tick(); expect_a("st_grant", 4'b0001, 2'd0, 1'b0, 1'b0);
        for (int k = 1; k <= STALL_HOLD; k++) begin
            tick(); expect_a("st_hold", 4'b0001, 2'd0, 1'b0, 1'b0);
            if (k == 1) pen_a = 4'b0001;
        end
`ifdef APB_BUS_ARBITER_TIMEOUT_EN
        tick(); expect_a("st_timeout", 4'b0000, 2'd0, 1'b0, 1'b1);
        req_a = '0; pen_a = '0;
        tick(); expect_a("st_to_pulse", 4'b0000, 2'd0, 1'b0, 1'b0);
        req_a = 4'b0001;
        tick(); expect_a("st2_grant", 4'b0001, 2'd0, 1'b0, 1'b0);
        for (int k = 1; k <= 15; k++) begin
            tick(); expect_a("st2_hold", 4'b0001, 2'd0, 1'b0, 1'b0);
            if (k == 1) pen_a = 4'b0001;
            if (k == 15) rdy_a = 1'b1;
        end
        tick(); expect_a("st2_done_wins", 4'b0000, 2'd0, 1'b1, 1'b0);
`else
        rdy_a = 1'b1;
        tick(); expect_a("st_done", 4'b0000, 2'd0, 1'b1, 1'b0);
`endif
        req_a = '0; pen_a = '0; rdy_a = 1'b0;

        // Round-robin: all request, zero-wait transfers, grants four cycles apart
        req_b = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            exp_oh = 4'b0001 << (n % 4);
            tick(); expect_b("rr_grant",  exp_oh, 2'(n % 4), 1'b0, 1'b0);
            tick(); expect_b("rr_setup",  exp_oh, 2'(n % 4), 1'b0, 1'b0);
            pen_b = exp_oh;
            tick(); expect_b("rr_access", exp_oh, 2'(n % 4), 1'b0, 1'b0);
            rdy_b = 1'b1;
            tick(); expect_b("rr_done",   4'b0000, 2'd0, 1'b1, 1'b0);
            pen_b = '0; rdy_b = 1'b0;
        end

        // Reset while master 3 is in ACCESS
        req_b = 4'b1000;
        tick(); expect_b("rr_m3_grant", 4'b1000, 2'd3, 1'b0, 1'b0);
        pen_b = 4'b1000;
        tick(); expect_b("rr_m3_access", 4'b1000, 2'd3, 1'b0, 1'b0);
        rst = 1'b1;
        tick(); expect_b("rr_reset", 4'b0000, 2'd0, 1'b0, 1'b0);
        rst = 1'b0; pen_b = '0; req_b = 4'b1111;
        tick(); expect_b("rr_post_reset", 4'b0001, 2'd0, 1'b0, 1'b0);

        // Withdrawals keep the grant-time pointer update; reset clears the pointer
        req_b = 4'b0000;
        tick(); expect_b("rr_withdraw", 4'b0000, 2'd0, 1'b0, 1'b0);
        req_b = 4'b1111;
        tick(); expect_b("rr_after_wd", 4'b0010, 2'd1, 1'b0, 1'b0);
        req_b = 4'b0000;
        tick(); expect_b("rr_withdraw1", 4'b0000, 2'd0, 1'b0, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0; req_b = 4'b1111;
        tick(); expect_b("rr_ptr_reset", 4'b0001, 2'd0, 1'b0, 1'b0);
        req_b = 4'b0000;
        tick(); expect_b("rr_withdraw0", 4'b0000, 2'd0, 1'b0, 1'b0);
        req_b = 4'b0101;
        tick(); expect_b("rr_scan_up", 4'b0100, 2'd2, 1'b0, 1'b0);
        req_b = 4'b0000;
        tick(); expect_b("rr_withdraw2", 4'b0000, 2'd0, 1'b0, 1'b0);
        req_b = 4'b0101;
        tick(); expect_b("rr_wrap", 4'b0001, 2'd0, 1'b0, 1'b0);
        req_b = 4'b0000;
        tick(); expect_b("rr_final_idle", 4'b0000, 2'd0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/apb_bus_arbiter.md
Name: apb_bus_arbiter

Overview:
- Grants the shared APB slave-side bus to one of NO_OF_MASTERS requesting masters at a time.
- Sits inside the master/slave interconnect, between the per-master PSEL request lines and the output mux that drives the slave bus.
- Holds the grant for one complete APB transfer, from SETUP until the ACCESS phase that completes with PREADY.
- Arbitration is fixed-priority or round-robin, selected by parameter.

Parameters:
- NO_OF_MASTERS, 4, number of requesting masters (>=1).
- MASTER_ID_WIDTH, 2, width of the encoded grant index; must be >= clog2(NO_OF_MASTERS), min 1.
- ARBITRATION_TYPE, 0, 0 = fixed priority (index 0 highest); 1 = round-robin.
- TIMEOUT_CYCLES, 16, transfer watchdog limit; used only with the optional feature; must be >= 2.

Ports:
- I_PCLK  in  1  clock; all logic on the rising edge.
- I_PRESET  in  1  synchronous, active-high reset.
- I_REQ  in  NO_OF_MASTERS  per-master request (OR of that master's PSEL bits).
- I_PENABLE  in  NO_OF_MASTERS  per-master PENABLE.
- I_PREADY  in  1  PREADY of the currently selected slave (already muxed).
- O_GNT  out  NO_OF_MASTERS  one-hot grant (registered).
- O_GNT_ID  out  MASTER_ID_WIDTH  binary index of the granted master; valid when O_GNT_VALID=1.
- O_GNT_VALID  out  1  bus owned by a master.
- O_XFER_DONE  out  1  one-cycle pulse: the granted transfer completed.
- O_TIMEOUT  out  1  one-cycle pulse: grant revoked by the watchdog.

Behaviour:
- Reset (I_PRESET=1 at a clock edge):
  - O_GNT=0, O_GNT_ID=0, O_GNT_VALID=0, O_XFER_DONE=0, O_TIMEOUT=0.
  - state=IDLE; round-robin pointer=0; watchdog counter=0.
  - Reset overrides everything, including mid-transfer; any grant drops the cycle after reset is sampled.
- States:
  - IDLE: no owner. If any I_REQ bit is set, pick winner W, go to SETUP, and register O_GNT=onehot(W), O_GNT_ID=W, O_GNT_VALID=1. Grant latency is 1 cycle from the sampled request.
  - SETUP: the owner is presenting its SETUP phase.
    - I_PENABLE[W]=1 -> ACCESS.
    - I_REQ[W]=0 (request withdrawn) -> IDLE, grant cleared, no O_XFER_DONE.
  - ACCESS: waiting for the slave.
    - I_PREADY=1 -> O_XFER_DONE=1 for the next cycle, grant cleared, -> IDLE.
    - I_PREADY=0 -> remain (wait states).
- Exactly one dead (IDLE) cycle separates consecutive grants. This holds even when the same master re-requests.
- Fixed priority: W = lowest set index of I_REQ.
- Round-robin:
  - W = first set bit of I_REQ scanning from the pointer upward, wrapping at NO_OF_MASTERS-1 -> 0.
  - On each grant, pointer = W+1, modulo NO_OF_MASTERS.
  - The pointer is unchanged by withdrawn or timed-out grants beyond that grant-time update.
- Request inputs of non-owners are ignored while a grant is active. I_PENABLE and I_PREADY are ignored in IDLE.
- O_GNT is always one-hot or zero. O_GNT_VALID equals the OR of O_GNT.
- NO_OF_MASTERS=1: the arbiter degenerates to the same FSM with O_GNT_ID=0.
- Simultaneous events:
  - I_PREADY=1 in ACCESS on the same cycle the watchdog expires: completion wins, O_XFER_DONE=1, O_TIMEOUT=0.
  - Withdraw and PENABLE in the same SETUP cycle: PENABLE wins (-> ACCESS).

Optional Feature:
- Macro: APB_BUS_ARBITER_TIMEOUT_EN.
- Defined:
  - A counter clears on every grant and increments each cycle in SETUP/ACCESS.
  - If it reaches TIMEOUT_CYCLES-1 without completion, the next cycle has O_TIMEOUT=1, grant cleared, state=IDLE.
  - A total of TIMEOUT_CYCLES owned cycles are allowed.
- Not defined: no counter is built, O_TIMEOUT is tied 0, and a grant persists until completion or withdrawal. Port list is identical in both builds.

Test Plan:
- Fixed priority, M=4: I_REQ=4'b1010 held -> O_GNT=4'b0010, O_GNT_ID=1, one cycle later. PENABLE, then PREADY after 2 wait states -> O_XFER_DONE pulse. 1 dead cycle, then O_GNT=4'b0010 again (master 1 still requesting).
- Round-robin, M=4: all four request continuously with zero-wait transfers -> grant order 0,1,2,3,0. Each grant is 4 cycles apart (grant, SETUP->ACCESS, done, idle).
- Withdrawal: master 2 granted, drops I_REQ[2] in SETUP -> O_GNT=0 next cycle, O_XFER_DONE=0, state IDLE.
- Reset mid-ACCESS: I_PRESET=1 while master 3 owns the bus -> all outputs 0 the next cycle; first post-reset round-robin grant goes to master 0 when I_REQ=4'b1111.
- Timeout (macro on, TIMEOUT_CYCLES=16): master 0 granted, I_PREADY held 0 -> O_TIMEOUT=1 exactly 16 cycles after O_GNT asserts, grant cleared. A repeat run with I_PREADY=1 on the 16th owned cycle gives O_XFER_DONE=1 and O_TIMEOUT=0.
- Macro off: the same stall holds O_GNT=4'b0001 for 100 cycles with O_TIMEOUT=0 throughout.
